event_serializer_8: RTL

- Upstream feeder for the 8-to-3 binary encoder.
- Latches events on 8 independent request lines, then presents them one at a time as a strictly one-hot vector with an enable.
- The encoder requires one-hot input, so its 3-bit code is always valid while en=1.
- Holds each grant until the consumer acknowledges it, then advances to the next pending line.

---
 rtl/encoder_pkg.sv | 6 +
 rtl/pick_onehot_8.sv | 26 ++
 rtl/event_serializer_8.sv | 80 ++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// encoder_pkg: shared constants and state type for 8-line event arbitration
package encoder_pkg;
  localparam int NLINES = 8;
  localparam int IDXW = 3;
  typedef enum logic {IDLE, PRESENT} state_t;
endpackage

// File: rtl/pick_onehot_8.sv
// pick_onehot_8: picks one set request, round-robin from ptr or lowest index first
module pick_onehot_8
  import encoder_pkg::*;
(
  input  logic [NLINES-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  input  logic              rr,
  output logic [NLINES-1:0] gnt,
  output logic [IDXW-1:0]   idx,
  output logic              any
);
  logic [IDXW-1:0] w_base;
  logic [IDXW-1:0] w_j;
  // scan downward in offset so the smallest offset from the base wins
  always_comb begin
    w_base = rr ? ptr : '0;
    w_j = '0;
    idx = '0;
    for (int i = NLINES - 1; i >= 0; i--) begin
      w_j = w_base + IDXW'(i);
      if (req[w_j]) idx = w_j;
    end
    any = |req;
    gnt = any ? NLINES'(1) << idx : '0;
  end
endmodule

// File: rtl/event_serializer_8.sv
// event_serializer_8: latches 8 event lines and presents them one-hot, one at a time
module event_serializer_8
  import encoder_pkg::*;
#(
  parameter bit EDGE = 1'b1,
  parameter bit RR   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NLINES-1:0] evt,
  input  logic [NLINES-1:0] mask,
  input  logic              ack,
  input  logic              ovf_clr,
  output logic [NLINES-1:0] onehot,
  output logic              en,
  output logic [NLINES-1:0] pend,
  output logic [NLINES-1:0] ovf
);
  state_t            r_state, w_state_d;
  logic [NLINES-1:0] r_evt_q, r_pend, r_ovf, r_onehot;
  logic [NLINES-1:0] w_hit, w_clr, w_gnt, w_onehot_d;
  logic [IDXW-1:0]   r_ptr, r_idx, w_idx;
  logic              r_en, w_en_d, w_any, w_load, w_adv;

  assign w_hit  = evt & ~mask & (EDGE ? ~r_evt_q : '1);
  assign w_load = (r_state == IDLE) && w_any;
  assign w_adv  = (r_state == PRESENT) && ack;
  assign w_clr  = w_load ? w_gnt : '0;

  // selection looks only at registered pending flags
  pick_onehot_8 u_pick (
    .req(r_pend),
    .ptr(r_ptr),
    .rr (RR),
    .gnt(w_gnt),
    .idx(w_idx),
    .any(w_any)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_d;
  end

  // next state: load a grant from IDLE, return to IDLE on ack
  always_comb w_state_d = w_load ? PRESENT : (w_adv ? IDLE : r_state);

  // next grant outputs, held stable while presenting
  always_comb begin
    w_onehot_d = w_load ? w_gnt : (w_adv ? '0 : r_onehot);
    w_en_d = w_load | (r_en & ~w_adv);
  end

  // capture, overflow, grant registers and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_q  <= '0;
      r_pend   <= '0;
      r_ovf    <= '0;
      r_onehot <= '0;
      r_en     <= 1'b0;
      r_idx    <= '0;
      r_ptr    <= '0;
    end else begin
      r_evt_q  <= evt;
      r_pend   <= (r_pend & ~w_clr) | w_hit;
      r_ovf    <= (r_ovf & ~{NLINES{ovf_clr}}) | (w_hit & r_pend & ~w_clr);
      r_onehot <= w_onehot_d;
      r_en     <= w_en_d;
      if (w_load) r_idx <= w_idx;
      if (w_adv) r_ptr <= r_idx + 1'b1;
    end
  end

  assign onehot = r_onehot;
  assign en     = r_en;
  assign pend   = r_pend;
  assign ovf    = r_ovf;
endmodule
